logic_addressable_latch: RTL
============================

# logic_addressable_latch

Parametrised, clocked successor to the 8-bit addressable latch in the TTM4 logic library. Holds a WIDTH-bit state register and supports the four classic modes (addressable latch, memory, demultiplexer, clear), plus out-of-range address detection and a saturating write counter for emulator debug. Sits in the logic/ group and is instantiated wherever the emulator models '259-style bit-addressable outputs of any width.

## Interface
- WIDTH, 8: number of latch bits; legal range 2..64.
- AW, $clog2(WIDTH): address width; derived, do not override.
- CNTW, 8: write-counter width.

- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  AW  bit address.
- D  input  1  data bit.
- nLE  input  1  latch enable, active low.
- nMR  input  1  master reset (clear), active low; synchronous.
- Q  output  WIDTH  latched state, registered.
- ERR  output  1  sticky: a write was attempted with A >= WIDTH.
- WCNT  output  CNTW  count of accepted single-bit writes, saturating.

## Operation
- Reset: Q = 0, ERR = 0, WCNT = 0, applied asynchronously while RST = 1.
- Mode decode each cycle from {nMR, nLE}:
  - 1,0 LATCH: Q[A] <= D; all other bits hold.
  - 1,1 MEMORY: Q holds.
  - 0,0 DEMUX: Q <= one-hot at A carrying D; all other bits <= 0.
  - 0,1 CLEAR: Q <= 0.
- Write = LATCH or DEMUX cycle.
- Address range: if A >= WIDTH on a write cycle, Q is not modified (in DEMUX, Q <= 0), WCNT does not increment, ERR <= 1. ERR clears only on RST.
- WCNT increments by 1 on every in-range write, including writes that do not change Q; holds at 2^CNTW-1.
- CLEAR does not touch ERR or WCNT.

## Timing
- Latency: inputs sampled at rising edge N; Q, ERR, WCNT valid after edge N. No combinational path from inputs to outputs.
- Back-to-back writes to different addresses on consecutive cycles all take effect; no handshake and no busy state.
- Same address written on consecutive cycles: last write wins.
- RST release: the first edge with RST = 0 processes inputs normally.
- RST asserted mid-operation overrides any mode that cycle.
- X/Z on A during a write: treated as out-of-range; never drive Z onto Q.

## Configuration
- LOGIC_LATCH_SHIFT_EN: when defined, adds input SH (1 bit).
  - SH = 1 with nMR = 1: shift mode; Q <= {D, Q[WIDTH-1:1]}, i.e. D enters the MSB and the LSB is discarded. A and nLE are ignored, WCNT increments, and the range check is skipped.
  - SH has no effect when nMR = 0; CLEAR and DEMUX take priority.
  - Priority: RST > nMR = 0 modes > SH > LATCH/MEMORY.
- Without the macro, SH does not exist and the behaviour is exactly the four modes above.

## Structure
- Package logic_latch_pkg contains:
  - mode encodings MODE_LATCH = 2'b10, MODE_MEMORY = 2'b11, MODE_DEMUX = 2'b00, MODE_CLEAR = 2'b01, each as the {nMR, nLE} pair;
  - a CNTW default constant.
- Sub-module logic_latch_decode: combinational decoder taking A and the WIDTH parameter and producing a WIDTH-bit one-hot select plus an in_range flag. It is shared by the LATCH and DEMUX paths.
- Top level: mode decode, Q register, ERR flag, saturating counter, optional shift path.

## Test plan
- WIDTH = 8, RST pulse mid-stream: Q = 8'h00, ERR = 0 and WCNT = 0 immediately, without waiting for a clock.
- LATCH writes of D = 1 to A = 0, 3, 7 on three consecutive cycles: Q = 8'h89, WCNT = 3; then MEMORY for 5 cycles with D toggling: Q stays 8'h89.
- From Q = 8'h89, DEMUX with A = 5, D = 1: Q = 8'h20 next cycle; then CLEAR: Q = 8'h00, WCNT = 4.
- WIDTH = 12, LATCH with A = 13, D = 1: Q unchanged, WCNT unchanged, ERR = 1; ERR persists through CLEAR and clears only on RST.
- CNTW = 2, six in-range writes: WCNT sequence 1, 2, 3, 3, 3, 3.
- LOGIC_LATCH_SHIFT_EN, WIDTH = 8, Q = 8'h00, SH = 1 with D = 1, 0, 1: Q = 8'h80, 8'h40, 8'hA0; then SH = 1 with nMR = 0, nLE = 1: Q = 8'h00.

Source files
------------

// File: rtl/logic_latch_pkg.sv
// Shared definitions for the addressable latch family.
//   MODE_*       : {nMR, nLE} mode encodings
//   CNTW_DEFAULT : default width of the saturating write counter
package logic_latch_pkg;

  localparam int unsigned CNTW_DEFAULT = 8;

  typedef logic [1:0] latchMode_t;

  localparam latchMode_t MODE_LATCH  = 2'b10;
  localparam latchMode_t MODE_MEMORY = 2'b11;
  localparam latchMode_t MODE_DEMUX  = 2'b00;
  localparam latchMode_t MODE_CLEAR  = 2'b01;

endpackage : logic_latch_pkg

// File: rtl/logic_latch_decode.sv
// Address decoder for the addressable latch: one-hot bit select plus range flag.
// Ports:
//   A       : bit address
//   sel     : one-hot select of bit A (all zero when A is out of range)
//   inRange : A addresses an existing bit (0 for A >= WIDTH or unknown A)
module logic_latch_decode #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(WIDTH)
) (
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] sel,
  output logic             inRange
);

  // Compare-per-bit so an unknown address selects nothing and reads as out of range.
  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (A == AW'(i)) begin
        sel[i] = 1'b1;
      end
    end
    inRange = |sel;
  end

endmodule : logic_latch_decode

// File: rtl/logic_addressable_latch.sv
// Clocked WIDTH-bit '259-style addressable latch with range error flag and
// saturating write counter.
// Optional feature macro: LOGIC_LATCH_SHIFT_EN adds the SH shift input.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   A    : bit address
//   D    : data bit
//   nLE  : latch enable, active low
//   nMR  : synchronous master reset / clear, active low
//   SH   : (LOGIC_LATCH_SHIFT_EN only) shift D into MSB when nMR = 1
//   Q    : latched state
//   ERR  : sticky out-of-range write flag
//   WCNT : saturating count of accepted writes
module logic_addressable_latch
  import logic_latch_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CNTW  = CNTW_DEFAULT,
  localparam int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    A,
  input  logic             D,
  input  logic             nLE,
  input  logic             nMR,
`ifdef LOGIC_LATCH_SHIFT_EN
  input  logic             SH,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             ERR,
  output logic [CNTW-1:0]  WCNT
);

  logic [WIDTH-1:0] sel;
  logic             inRange;
  logic             shiftMode;
  latchMode_t       mode;
  logic [WIDTH-1:0] qNext;
  logic             errNext;
  logic             cntInc;

  logic_latch_decode #(.WIDTH(WIDTH)) uDecode (
    .A       (A),
    .sel     (sel),
    .inRange (inRange)
  );

  assign mode = {nMR, nLE};

  // Shift only applies while nMR is high; clear/demux win otherwise.
`ifdef LOGIC_LATCH_SHIFT_EN
  assign shiftMode = nMR & SH;
`else
  assign shiftMode = 1'b0;
`endif

  // Next-state for Q / ERR and counter increment request.
  always_comb begin
    qNext   = Q;
    errNext = ERR;
    cntInc  = 1'b0;
    if (shiftMode) begin
      qNext  = {D, Q[WIDTH-1:1]};
      cntInc = 1'b1;
    end else begin
      case (mode)
        MODE_LATCH: begin
          if (inRange) begin
            qNext  = (Q & ~sel) | (sel & {WIDTH{D}});
            cntInc = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
        MODE_DEMUX: begin
          // Out-of-range demux still clears the other bits (sel is all zero).
          qNext = sel & {WIDTH{D}};
          if (inRange) begin
            cntInc = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
        MODE_CLEAR:  qNext = '0;
        MODE_MEMORY: qNext = Q;
        default:     qNext = Q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q    <= '0;
      ERR  <= 1'b0;
      WCNT <= '0;
    end else begin
      Q   <= qNext;
      ERR <= errNext;
      if (cntInc && (WCNT != {CNTW{1'b1}})) begin
        WCNT <= WCNT + CNTW'(1);
      end
    end
  end

endmodule : logic_addressable_latch
